inst_wb_multi: RTL and testbench

INST_WB_MULTI -- requirements
Module: inst_wb_multi

---
 rtl/inst_wb_multi.sv | 259 +++++++++++++++++++++++++
 tb/tb_inst_wb_multi.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_wb_multi.sv
// Multi-lane writeback stage: registers a bundle of lane results for the register
// file and serialises the retired lanes one at a time onto the debug port.
module inst_wb_multi #(
  parameter int unsigned LANES       = 2,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned RADDR_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            dbus_ready,
  input  logic [LANES-1:0]                ex_lane_valid,
  input  logic [LANES-1:0]                ex_we,
  input  logic [LANES-1:0]                ex_load,
  input  logic [LANES-1:0]                ex_exc,
  input  logic [LANES*RADDR_WIDTH-1:0]    ex_waddr,
  input  logic [LANES*DATA_WIDTH-1:0]     ex_wdata,
  input  logic [LANES*32-1:0]             ex_pc,
  input  logic [LANES*2-1:0]              ex_vaddr_lo,
  input  logic [LANES*3-1:0]              ex_op,
  input  logic [LANES*4-1:0]              ex_be,
  input  logic [LANES*DATA_WIDTH-1:0]     dcache_rddata,
  output logic                            wb_valid,
  output logic [LANES-1:0]                wb_we,
  output logic [LANES*RADDR_WIDTH-1:0]    wb_waddr,
  output logic [LANES*DATA_WIDTH-1:0]     wb_wdata,
  output logic                            dbg_valid,
  input  logic                            dbg_ready,
  output logic [31:0]                     dbg_pc,
  output logic [3:0]                      dbg_wbe,
  output logic [RADDR_WIDTH-1:0]          dbg_waddr,
  output logic [DATA_WIDTH-1:0]           dbg_wdata
);

  localparam int unsigned PTR_W = 2;

  typedef enum logic {IDLE, DRAIN} state_e;

  state_e                             state_q, state_d;
  logic [PTR_W-1:0]                   ptr_q, ptr_d;
  logic [LANES-1:0]                   emit_q, emit_d;
  logic [LANES-1:0][31:0]             pc_q, pc_d;
  logic [LANES-1:0][3:0]              wbe_q, wbe_d;
  logic [LANES-1:0][RADDR_WIDTH-1:0]  waddr_q, waddr_d;
  logic [LANES-1:0][DATA_WIDTH-1:0]   wdata_q, wdata_d;

  logic                               wb_valid_q, wb_valid_d;
  logic [LANES-1:0]                   wb_we_q, wb_we_d;
  logic [LANES*RADDR_WIDTH-1:0]       wb_waddr_q, wb_waddr_d;
  logic [LANES*DATA_WIDTH-1:0]        wb_wdata_q, wb_wdata_d;
  logic                               dbg_valid_q, dbg_valid_d;
  logic [31:0]                        dbg_pc_q, dbg_pc_d;
  logic [3:0]                         dbg_wbe_q, dbg_wbe_d;
  logic [RADDR_WIDTH-1:0]             dbg_waddr_q, dbg_waddr_d;
  logic [DATA_WIDTH-1:0]              dbg_wdata_q, dbg_wdata_d;

  logic [LANES-1:0]                   emit_c, we_raw_c, we_c;
  logic [LANES-1:0][DATA_WIDTH-1:0]   data_c;
  logic [LANES-1:0][3:0]              wbe_c;
  logic [LANES-1:0][RADDR_WIDTH-1:0]  addr_c;
  logic                               seen_exc_c;
  logic [DATA_WIDTH-1:0]              rd_c;
  logic [7:0]                         byte_c;
  logic [15:0]                        half_c;
  logic [1:0]                         lo_c;

  logic                               first_found_c, nxt_found_c;
  logic [PTR_W-1:0]                   first_idx_c, nxt_idx_c;
  logic                               last_hs_c, accept_c;

  // Per-lane load extraction, precise squash and write-enable generation.
  always_comb begin
    emit_c     = '0;
    we_raw_c   = '0;
    data_c     = '0;
    wbe_c      = '0;
    addr_c     = '0;
    seen_exc_c = 1'b0;
    rd_c       = '0;
    byte_c     = '0;
    half_c     = '0;
    lo_c       = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      rd_c      = dcache_rddata[i*DATA_WIDTH +: DATA_WIDTH];
      lo_c      = ex_vaddr_lo[i*2 +: 2];
      byte_c    = 8'(rd_c >> {lo_c, 3'b000});
      half_c    = 16'(rd_c >> {lo_c[1], 4'b0000});
      addr_c[i] = ex_waddr[i*RADDR_WIDTH +: RADDR_WIDTH];
      if (ex_load[i]) begin
        case (ex_op[i*3 +: 3])
          3'd0:    data_c[i] = {{(DATA_WIDTH-8){byte_c[7]}}, byte_c};
          3'd1:    data_c[i] = {{(DATA_WIDTH-8){1'b0}}, byte_c};
          3'd2:    data_c[i] = {{(DATA_WIDTH-16){half_c[15]}}, half_c};
          3'd3:    data_c[i] = {{(DATA_WIDTH-16){1'b0}}, half_c};
          default: data_c[i] = rd_c;
        endcase
      end else begin
        data_c[i] = ex_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
      emit_c[i]   = ex_lane_valid[i] && !seen_exc_c;
      we_raw_c[i] = (ex_we[i] || ex_load[i]) && emit_c[i] && !ex_exc[i] && (addr_c[i] != '0);
      if (ex_exc[i])       wbe_c[i] = 4'h0;
      else if (ex_we[i])   wbe_c[i] = 4'hF;
      else if (ex_load[i]) wbe_c[i] = ex_be[i*4 +: 4];
      else                 wbe_c[i] = 4'h0;
      if (ex_lane_valid[i] && ex_exc[i]) seen_exc_c = 1'b1;
    end
  end

  // A younger lane writing the same register makes the older write redundant.
  always_comb begin
    we_c = we_raw_c;
    for (int i = 0; i < int'(LANES); i++) begin
      for (int k = 0; k < int'(LANES); k++) begin
        if (k > i && we_raw_c[k] && addr_c[k] == addr_c[i]) we_c[i] = 1'b0;
      end
    end
  end

  // Lowest emit lane of the incoming bundle and next buffered lane after the pointer.
  always_comb begin
    first_found_c = 1'b0;
    first_idx_c   = '0;
    nxt_found_c   = 1'b0;
    nxt_idx_c     = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (!first_found_c && emit_c[i]) begin
        first_found_c = 1'b1;
        first_idx_c   = PTR_W'(i);
      end
      if (!nxt_found_c && emit_q[i] && (i > int'(ptr_q))) begin
        nxt_found_c = 1'b1;
        nxt_idx_c   = PTR_W'(i);
      end
    end
  end

  assign last_hs_c = (state_q == DRAIN) && dbg_ready && !nxt_found_c;
  assign in_ready  = dbus_ready && ((state_q == IDLE) || last_hs_c);
  assign accept_c  = in_valid && in_ready;

  // Next-state: writeback register, debug buffer and drain sequencing.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    emit_d      = emit_q;
    pc_d        = pc_q;
    wbe_d       = wbe_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    wb_valid_d  = 1'b0;
    wb_we_d     = '0;
    wb_waddr_d  = '0;
    wb_wdata_d  = '0;
    dbg_valid_d = dbg_valid_q;
    dbg_pc_d    = dbg_pc_q;
    dbg_wbe_d   = dbg_wbe_q;
    dbg_waddr_d = dbg_waddr_q;
    dbg_wdata_d = dbg_wdata_q;

    if (accept_c) begin
      wb_valid_d = 1'b1;
      wb_we_d    = we_c;
      wb_waddr_d = ex_waddr;
      for (int i = 0; i < int'(LANES); i++) begin
        wb_wdata_d[i*DATA_WIDTH +: DATA_WIDTH] = data_c[i];
        pc_d[i] = ex_pc[i*32 +: 32];
      end
      emit_d  = emit_c;
      wbe_d   = wbe_c;
      waddr_d = addr_c;
      wdata_d = data_c;
      if (first_found_c) begin
        state_d     = DRAIN;
        ptr_d       = first_idx_c;
        dbg_valid_d = 1'b1;
        dbg_pc_d    = ex_pc[32*int'(first_idx_c) +: 32];
        dbg_wbe_d   = wbe_c[first_idx_c];
        dbg_waddr_d = addr_c[first_idx_c];
        dbg_wdata_d = data_c[first_idx_c];
      end else begin
        state_d     = IDLE;
        ptr_d       = '0;
        dbg_valid_d = 1'b0;
        dbg_pc_d    = '0;
        dbg_wbe_d   = '0;
        dbg_waddr_d = '0;
        dbg_wdata_d = '0;
      end
    end else if (state_q == DRAIN && dbg_ready) begin
      if (nxt_found_c) begin
        ptr_d       = nxt_idx_c;
        dbg_pc_d    = pc_q[nxt_idx_c];
        dbg_wbe_d   = wbe_q[nxt_idx_c];
        dbg_waddr_d = waddr_q[nxt_idx_c];
        dbg_wdata_d = wdata_q[nxt_idx_c];
      end else begin
        state_d     = IDLE;
        ptr_d       = '0;
        emit_d      = '0;
        dbg_valid_d = 1'b0;
        dbg_pc_d    = '0;
        dbg_wbe_d   = '0;
        dbg_waddr_d = '0;
        dbg_wdata_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      emit_q      <= '0;
      pc_q        <= '0;
      wbe_q       <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= '0;
      wb_waddr_q  <= '0;
      wb_wdata_q  <= '0;
      dbg_valid_q <= 1'b0;
      dbg_pc_q    <= '0;
      dbg_wbe_q   <= '0;
      dbg_waddr_q <= '0;
      dbg_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      emit_q      <= emit_d;
      pc_q        <= pc_d;
      wbe_q       <= wbe_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_we_q     <= wb_we_d;
      wb_waddr_q  <= wb_waddr_d;
      wb_wdata_q  <= wb_wdata_d;
      dbg_valid_q <= dbg_valid_d;
      dbg_pc_q    <= dbg_pc_d;
      dbg_wbe_q   <= dbg_wbe_d;
      dbg_waddr_q <= dbg_waddr_d;
      dbg_wdata_q <= dbg_wdata_d;
    end
  end

  assign wb_valid  = wb_valid_q;
  assign wb_we     = wb_we_q;
  assign wb_waddr  = wb_waddr_q;
  assign wb_wdata  = wb_wdata_q;
  assign dbg_valid = dbg_valid_q;
  assign dbg_pc    = dbg_pc_q;
  assign dbg_wbe   = dbg_wbe_q;
  assign dbg_waddr = dbg_waddr_q;
  assign dbg_wdata = dbg_wdata_q;

endmodule

// File: tb/tb_inst_wb_multi.sv
// Directed bench for inst_wb_multi with two lanes: load extraction, squash, collapse,
// back-pressure on both buses, drain ordering and reset during drain.
module tb_inst_wb_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        dbus_ready;
  logic [1:0]  ex_lane_valid, ex_we, ex_load, ex_exc;
  logic [9:0]  ex_waddr;
  logic [63:0] ex_wdata, ex_pc, dcache_rddata;
  logic [3:0]  ex_vaddr_lo;
  logic [5:0]  ex_op;
  logic [7:0]  ex_be;
  logic        wb_valid;
  logic [1:0]  wb_we;
  logic [9:0]  wb_waddr;
  logic [63:0] wb_wdata;
  logic        dbg_valid, dbg_ready;
  logic [31:0] dbg_pc, dbg_wdata;
  logic [3:0]  dbg_wbe;
  logic [4:0]  dbg_waddr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  inst_wb_multi #(.LANES(2), .DATA_WIDTH(32), .RADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .dbus_ready(dbus_ready),
    .ex_lane_valid(ex_lane_valid), .ex_we(ex_we), .ex_load(ex_load), .ex_exc(ex_exc),
    .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_pc(ex_pc), .ex_vaddr_lo(ex_vaddr_lo),
    .ex_op(ex_op), .ex_be(ex_be), .dcache_rddata(dcache_rddata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_pc(dbg_pc), .dbg_wbe(dbg_wbe),
    .dbg_waddr(dbg_waddr), .dbg_wdata(dbg_wdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_lane(input int l, input logic v, input logic we, input logic ld,
                          input logic ex, input logic [4:0] wa, input logic [31:0] wd,
                          input logic [31:0] pc, input logic [1:0] lo, input logic [2:0] op,
                          input logic [3:0] be, input logic [31:0] rd);
    ex_lane_valid[l]          = v;
    ex_we[l]                  = we;
    ex_load[l]                = ld;
    ex_exc[l]                 = ex;
    ex_waddr[l*5 +: 5]        = wa;
    ex_wdata[l*32 +: 32]      = wd;
    ex_pc[l*32 +: 32]         = pc;
    ex_vaddr_lo[l*2 +: 2]     = lo;
    ex_op[l*3 +: 3]           = op;
    ex_be[l*4 +: 4]           = be;
    dcache_rddata[l*32 +: 32] = rd;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; dbus_ready = 1'b1; dbg_ready = 1'b1;
    set_lane(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 2'd0, 3'd0, 4'h0, 32'h0);
    set_lane(1, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 2'd0, 3'd0, 4'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_we", 64'(wb_we), 64'd0);
    chk("rst_dbg_valid", 64'(dbg_valid), 64'd0);
    chk("rst_dbg_pc", 64'(dbg_pc), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Lane0 LB sign-extended, lane1 ALU; debug held to watch ordering.
    @(negedge clk);
    set_lane(0, 1, 0, 1, 0, 5'd3, 32'h0, 32'h100, 2'd2, 3'd0, 4'h4, 32'h0080_0000);
    set_lane(1, 1, 1, 0, 0, 5'd4, 32'd5, 32'h104, 2'd0, 3'd4, 4'h0, 32'h0);
    in_valid = 1'b1; dbg_ready = 1'b0; #1;
    chk("t1_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk); in_valid = 1'b0; #1;
    chk("t1_wb_valid", 64'(wb_valid), 64'd1);
    chk("t1_wb_we", 64'(wb_we), 64'd3);
    chk("t1_wb_waddr", 64'(wb_waddr), 64'h083);
    chk("t1_wdata0", 64'(wb_wdata[31:0]), 64'hFFFF_FF80);
    chk("t1_wdata1", 64'(wb_wdata[63:32]), 64'd5);
    chk("t1_dbg_valid", 64'(dbg_valid), 64'd1);
    chk("t1_dbg_pc0", 64'(dbg_pc), 64'h100);
    chk("t1_dbg_wbe0", 64'(dbg_wbe), 64'h4);
    chk("t1_dbg_wdata0", 64'(dbg_wdata), 64'hFFFF_FF80);
    chk("t1_in_ready_drain", 64'(in_ready), 64'd0);
    @(negedge clk); dbg_ready = 1'b1; #1;
    chk("t1_wb_one_cycle", 64'(wb_valid), 64'd0);
    chk("t1_dbg_pc0_held", 64'(dbg_pc), 64'h100);
    chk("t1_in_ready_notlast", 64'(in_ready), 64'd0);
    @(negedge clk); #1;
    chk("t1_dbg_pc1", 64'(dbg_pc), 64'h104);
    chk("t1_dbg_wbe1", 64'(dbg_wbe), 64'hF);
    chk("t1_dbg_waddr1", 64'(dbg_waddr), 64'd4);
    chk("t1_in_ready_last", 64'(in_ready), 64'd1);
    @(negedge clk); #1;
    chk("t1_dbg_done", 64'(dbg_valid), 64'd0);

    // Exception on lane0 squashes lane1.
    @(negedge clk);
    set_lane(0, 1, 1, 0, 1, 5'd5, 32'h77, 32'h200, 2'd0, 3'd4, 4'h0, 32'h0);
    set_lane(1, 1, 1, 0, 0, 5'd6, 32'd9, 32'h204, 2'd0, 3'd4, 4'h0, 32'h0);
    in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0; #1;
    chk("t2_wb_valid", 64'(wb_valid), 64'd1);
    chk("t2_wb_we", 64'(wb_we), 64'd0);
    chk("t2_dbg_pc", 64'(dbg_pc), 64'h200);
    chk("t2_dbg_wbe", 64'(dbg_wbe), 64'h0);
    chk("t2_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk); #1;
    chk("t2_dbg_done", 64'(dbg_valid), 64'd0);

    // Same-address collapse, then reload on final-lane handshake with waddr 0.
    @(negedge clk);
    set_lane(0, 1, 1, 0, 0, 5'd7, 32'h11, 32'h300, 2'd0, 3'd4, 4'h0, 32'h0);
    set_lane(1, 1, 1, 0, 0, 5'd7, 32'h22, 32'h304, 2'd0, 3'd4, 4'h0, 32'h0);
    in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0; #1;
    chk("t3_wb_we", 64'(wb_we), 64'd2);
    chk("t3_wdata1", 64'(wb_wdata[63:32]), 64'h22);
    chk("t3_dbg_pc0", 64'(dbg_pc), 64'h300);
    @(negedge clk);
    set_lane(0, 1, 1, 0, 0, 5'd0, 32'h33, 32'h400, 2'd0, 3'd4, 4'h0, 32'h0);
    set_lane(1, 1, 1, 0, 0, 5'd8, 32'h44, 32'h404, 2'd0, 3'd4, 4'h0, 32'h0);
    in_valid = 1'b1; #1;
    chk("t3_dbg_pc1", 64'(dbg_pc), 64'h304);
    chk("t3_in_ready_reload", 64'(in_ready), 64'd1);
    @(negedge clk); in_valid = 1'b0; #1;
    chk("t3b_wb_valid", 64'(wb_valid), 64'd1);
    chk("t3b_wb_we", 64'(wb_we), 64'd2);
    chk("t3b_dbg_pc0", 64'(dbg_pc), 64'h400);
    @(negedge clk); #1;
    chk("t3b_dbg_pc1", 64'(dbg_pc), 64'h404);
    @(negedge clk); #1;
    chk("t3b_dbg_done", 64'(dbg_valid), 64'd0);

    // Data bus stall, then back-to-back single-lane bundles.
    @(negedge clk);
    set_lane(0, 1, 1, 0, 0, 5'd9, 32'hA5, 32'h500, 2'd0, 3'd4, 4'h0, 32'h0);
    set_lane(1, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 2'd0, 3'd0, 4'h0, 32'h0);
    in_valid = 1'b1; dbus_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t4_stall_in_ready", 64'(in_ready), 64'd0);
      chk("t4_stall_wb_valid", 64'(wb_valid), 64'd0);
      @(negedge clk);
    end
    dbus_ready = 1'b1; #1;
    chk("t4_in_ready_rise", 64'(in_ready), 64'd1);
    @(negedge clk);
    set_lane(0, 1, 0, 1, 0, 5'd10, 32'h0, 32'h504, 2'd2, 3'd3, 4'hC, 32'h8001_0000); #1;
    chk("t4a_wdata0", 64'(wb_wdata[31:0]), 64'hA5);
    chk("t4a_wb_we", 64'(wb_we), 64'd1);
    chk("t4a_dbg_pc", 64'(dbg_pc), 64'h500);
    chk("t4a_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    set_lane(0, 1, 0, 1, 0, 5'd11, 32'h0, 32'h508, 2'd0, 3'd2, 4'h3, 32'h0000_8002); #1;
    chk("t4b_wb_valid", 64'(wb_valid), 64'd1);
    chk("t4b_wdata0", 64'(wb_wdata[31:0]), 64'h0000_8001);
    chk("t4b_dbg_pc", 64'(dbg_pc), 64'h504);
    chk("t4b_dbg_wbe", 64'(dbg_wbe), 64'hC);
    @(negedge clk); in_valid = 1'b0; #1;
    chk("t4c_wdata0", 64'(wb_wdata[31:0]), 64'hFFFF_8002);
    chk("t4c_dbg_waddr", 64'(dbg_waddr), 64'd11);
    @(negedge clk); #1;
    chk("t4_idle_wb_valid", 64'(wb_valid), 64'd0);
    chk("t4_idle_dbg_valid", 64'(dbg_valid), 64'd0);

    // Debug port stalled four cycles in DRAIN.
    @(negedge clk);
    set_lane(0, 1, 1, 0, 0, 5'd12, 32'd1, 32'h600, 2'd0, 3'd4, 4'h0, 32'h0);
    set_lane(1, 1, 1, 0, 0, 5'd13, 32'd2, 32'h604, 2'd0, 3'd4, 4'h0, 32'h0);
    in_valid = 1'b1; dbg_ready = 1'b0;
    @(negedge clk);
    set_lane(0, 1, 1, 0, 0, 5'd12, 32'd1, 32'h6F0, 2'd0, 3'd4, 4'h0, 32'h0); #1;
    chk("t5_wb_valid", 64'(wb_valid), 64'd1);
    chk("t5_dbg_pc", 64'(dbg_pc), 64'h600);
    chk("t5_in_ready", 64'(in_ready), 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk("t5_stall_wb_valid", 64'(wb_valid), 64'd0);
      chk("t5_stall_dbg_valid", 64'(dbg_valid), 64'd1);
      chk("t5_stall_dbg_pc", 64'(dbg_pc), 64'h600);
      chk("t5_stall_dbg_wdata", 64'(dbg_wdata), 64'd1);
      chk("t5_stall_in_ready", 64'(in_ready), 64'd0);
    end
    @(negedge clk); dbg_ready = 1'b1; #1;
    chk("t5_rel_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk); in_valid = 1'b0; #1;
    chk("t5_dbg_pc1", 64'(dbg_pc), 64'h604);
    chk("t5_dbg_waddr1", 64'(dbg_waddr), 64'd13);
    @(negedge clk); #1;
    chk("t5_dbg_done", 64'(dbg_valid), 64'd0);
    chk("t5_wb_done", 64'(wb_valid), 64'd0);

    // Reset on first DRAIN cycle, then reset beats a simultaneous accept.
    @(negedge clk);
    set_lane(0, 1, 1, 0, 0, 5'd14, 32'd3, 32'h700, 2'd0, 3'd4, 4'h0, 32'h0);
    set_lane(1, 1, 1, 0, 0, 5'd15, 32'd4, 32'h704, 2'd0, 3'd4, 4'h0, 32'h0);
    in_valid = 1'b1;
    @(negedge clk); #1;
    chk("t6_dbg_valid", 64'(dbg_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("t6_rst_dbg_valid", 64'(dbg_valid), 64'd0);
    chk("t6_rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("t6_rst_dbg_pc", 64'(dbg_pc), 64'd0);
    chk("t6_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk); #1;
    chk("t6_rst_prio_wb_valid", 64'(wb_valid), 64'd0);
    chk("t6_rst_prio_dbg_valid", 64'(dbg_valid), 64'd0);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk); #1;
    chk("t6_idle_in_ready", 64'(in_ready), 64'd1);
    chk("t6_idle_dbg_valid", 64'(dbg_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
